// File: rtl/climate_scheduler.sv
// rtl/climate_scheduler.sv - registered climate mode FSM with hysteresis, dwell, fan ramp
// Optional AC compressor lockout enabled by CLIMATE_AC_LOCKOUT_EN.
module climate_scheduler #(
  parameter int MIN_DWELL  = 4,
  parameter int AC_LOCKOUT = 8,
  parameter int T_WIND     = 5,
  parameter int T_FAN      = 8,
  parameter int T_AC       = 11,
  parameter int HYST       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] TEMP,
  input  logic       en,
  output logic       WIND,
  output logic       FAN,
  output logic       AC,
  output logic [3:0] fan_out,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WIND = 2'd1;
  localparam logic [1:0] S_FAN  = 2'd2;
  localparam logic [1:0] S_COOL = 2'd3;

  localparam int DW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [3:0] TH_WIND = 4'(T_WIND);
  localparam logic [3:0] TH_FAN  = 4'(T_FAN);
  localparam logic [3:0] TH_AC   = 4'(T_AC);

  logic [1:0]    cur;
  logic [1:0]    nxt;
  logic [DW-1:0] dwell;
  logic [1:0]    level;
  logic [3:0]    thr;
  logic [5:0]    temp_h;
  logic          dwell_ok;
  logic          lock_ok;
  logic          step_up;
  logic          step_down;
  logic          wind_d;
  logic          fan_d;
  logic          ac_d;
  logic [3:0]    fan_target;

  always_comb begin
    level = 2'd0;
    if (TEMP >= TH_AC)        level = 2'd3;
    else if (TEMP >= TH_FAN)  level = 2'd2;
    else if (TEMP >= TH_WIND) level = 2'd1;
  end

  always_comb begin
    thr = 4'd0;
    case (cur)
      S_WIND:  thr = TH_WIND;
      S_FAN:   thr = TH_FAN;
      S_COOL:  thr = TH_AC;
      default: thr = 4'd0;
    endcase
  end

  // TEMP < thr - HYST, rearranged so the subtraction can never wrap
  assign temp_h    = {2'b00, TEMP} + 6'(HYST);
  assign dwell_ok  = (dwell >= DW'(MIN_DWELL - 1));
  assign step_up   = (level > cur) && dwell_ok && ((cur != S_FAN) || lock_ok);
  assign step_down = (cur != S_IDLE) && (temp_h < {2'b00, thr}) && dwell_ok;

`ifdef CLIMATE_AC_LOCKOUT_EN
  localparam int LW = (AC_LOCKOUT > 0) ? $clog2(AC_LOCKOUT + 1) : 1;
  logic [LW-1:0] lockout;

  always_ff @(posedge clk) begin
    if (rst) begin
      lockout <= '0;
    end else if ((cur == S_COOL) && (nxt != S_COOL)) begin
      lockout <= LW'(AC_LOCKOUT);
    end else if (lockout != '0) begin
      lockout <= lockout - 1'b1;
    end
  end

  // the counter reaches zero on this same edge, so re-entry lands AC_LOCKOUT edges after exit
  assign lock_ok = (lockout <= LW'(1));
`else
  logic unused_ac_lockout;
  assign unused_ac_lockout = (AC_LOCKOUT != 0);
  assign lock_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_IDLE;
      dwell   <= '0;
      WIND    <= 1'b0;
      FAN     <= 1'b0;
      AC      <= 1'b0;
      fan_out <= 4'd0;
    end else begin
      cur  <= nxt;
      WIND <= wind_d;
      FAN  <= fan_d;
      AC   <= ac_d;
      if (nxt != cur)    dwell <= '0;
      else if (!dwell_ok) dwell <= dwell + 1'b1;
      if (fan_out < fan_target)      fan_out <= fan_out + 4'd1;
      else if (fan_out > fan_target) fan_out <= fan_out - 4'd1;
    end
  end

  always_comb begin
    nxt = cur;
    if (!en)            nxt = S_IDLE;
    else if (step_up)   nxt = cur + 2'd1;
    else if (step_down) nxt = cur - 2'd1;
  end

  always_comb begin
    wind_d     = (nxt == S_WIND);
    fan_d      = (nxt == S_FAN) || (nxt == S_COOL);
    ac_d       = (nxt == S_COOL);
    fan_target = 4'd0;
    case (cur)
      S_FAN:   fan_target = (TEMP == 4'd0) ? 4'd1 : TEMP;
      S_COOL:  fan_target = 4'd4;
      default: fan_target = 4'd0;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_climate_scheduler.sv
// tb/tb_climate_scheduler.sv - scoreboard bench for climate_scheduler
module tb_climate_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] TEMP;
  logic       en;
  logic       WIND;
  logic       FAN;
  logic       AC;
  logic [3:0] fan_out;
  logic [1:0] state;

  climate_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .TEMP    (TEMP),
    .en      (en),
    .WIND    (WIND),
    .FAN     (FAN),
    .AC      (AC),
    .fan_out (fan_out),
    .state   (state)
  );

  always #5 clk = ~clk;

`ifdef CLIMATE_AC_LOCKOUT_EN
  localparam int LOCK_EDGES = 8;
  localparam bit LOCK_ON    = 1'b1;
`else
  localparam int LOCK_EDGES = 4;
  localparam bit LOCK_ON    = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] st;
    logic       w;
    logic       f;
    logic       a;
    logic [3:0] fo;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  int m_st = 0, m_dw = 0, m_since = 255, m_fan = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // Reference model: lockout tracked as edges elapsed since the last COOL exit.
  task automatic model_edge(input int t, input bit e, input bit r);
    int lvl, thr, nst, tgt;
    bit ok;
    exp_t x;
    if (r) begin
      m_st = 0; m_dw = 0; m_since = 255; m_fan = 0;
    end else begin
      lvl = (t >= 11) ? 3 : (t >= 8) ? 2 : (t >= 5) ? 1 : 0;
      thr = (m_st == 1) ? 5 : (m_st == 2) ? 8 : (m_st == 3) ? 11 : 0;
      ok  = (m_dw >= 3);
      nst = m_st;
      if (!e) nst = 0;
      else if (lvl > m_st && ok && (m_st != 2 || !LOCK_ON || m_since + 1 >= 8)) nst = m_st + 1;
      else if (m_st > 0 && t < thr - 1 && ok) nst = m_st - 1;
      tgt = (m_st == 2) ? ((t < 1) ? 1 : t) : (m_st == 3) ? 4 : 0;
      if (m_fan < tgt) m_fan++;
      else if (m_fan > tgt) m_fan--;
      if (m_st == 3 && nst != 3) m_since = 0;
      else if (m_since < 255) m_since++;
      m_dw = (nst != m_st) ? 0 : ((m_dw < 3) ? m_dw + 1 : 3);
      m_st = nst;
    end
    x.st = 2'(m_st);
    x.w  = (m_st == 1);
    x.f  = (m_st >= 2);
    x.a  = (m_st == 3);
    x.fo = 4'(m_fan);
    sb.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("state", state, x.st);
      check("WIND", WIND, x.w);
      check("FAN", FAN, x.f);
      check("AC", AC, x.a);
      check("fan_out", fan_out, x.fo);
    end
  endtask

  task automatic step(input int t, input bit e, input bit r);
    TEMP = 4'(t);
    en   = e;
    rst  = r;
    model_edge(t, e, r);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w_edge, f_edge, a_edge, hold_t;
    TEMP = 4'd12; en = 1'b1; rst = 1'b1;
    #2;

    // reset held with hot input
    for (int i = 0; i < 2; i++) begin
      step(12, 1, 1);
      check("rst_state", state, 0);
      check("rst_fan_out", fan_out, 0);
    end

    // climb from IDLE to COOL
    w_edge = 0; f_edge = 0; a_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      step(12, 1, 0);
      if (WIND && w_edge == 0) w_edge = i;
      if (FAN && f_edge == 0)  f_edge = i;
      if (AC && a_edge == 0)   a_edge = i;
    end
    check("climb_wind_edge", w_edge, 4);
    check("climb_fan_edge", f_edge, 8);
    check("climb_ac_edge", a_edge, 12);
    check("climb_fan_settle", fan_out, 4);

    // COOL exit then immediate demand for COOL again
    step(9, 1, 0);
    check("lock_exit_state", state, 2);
    a_edge = 0;
    for (int i = 1; i <= 30 && a_edge == 0; i++) begin
      step(12, 1, 0);
      if (AC) a_edge = i;
    end
    check("lock_reentry_edge", a_edge, LOCK_EDGES);

    // fan ramp in FAN
    for (int i = 0; i < 4; i++) step(12, 1, 0);
    step(9, 1, 0);
    check("ramp_state", state, 2);
    for (int i = 0; i < 12; i++) step(9, 1, 0);
    check("ramp_to_9", fan_out, 9);
    for (int i = 0; i < 3; i++) step(8, 1, 0);
    check("ramp_to_8", fan_out, 8);

    // hysteresis band
    for (int i = 0; i < 6; i++) step(7, 1, 0);
    check("hyst_hold", state, 2);
    step(6, 1, 0);
    check("hyst_drop_state", state, 1);
    check("hyst_drop_fan", FAN, 0);

    // disable from COOL
    for (int i = 0; i < 30; i++) step(12, 1, 0);
    check("dis_pre_state", state, 3);
    step(12, 0, 0);
    check("dis_state", state, 0);
    check("dis_ac", AC, 0);
    check("dis_fan_out", fan_out, 4);
    a_edge = 0;
    for (int i = 1; i <= 20 && a_edge == 0; i++) begin
      step(12, 1, 0);
      if (i <= 4) check("dis_ramp_down", fan_out, 4 - i);
      if (AC) a_edge = i;
    end
    check("dis_reentry_edge", a_edge, 12);

    // reset mid-operation
    step(12, 1, 1);
    check("midrst_state", state, 0);
    check("midrst_fan_out", fan_out, 0);

    // random soak
    hold_t = 12;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) hold_t = $urandom_range(0, 15);
      step(hold_t, $urandom_range(0, 15) != 0, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
